fetch_stall_control: RTL and testbench

Owns the program counter and the Fetch-to-Decode pipeline register, and acts on the stall request from the hazard detection unit. Each cycle it advances the PC, holds it, or redirects it to a taken-branch target. It loads, holds or flushes the IF/ID register to match, and drives the bubble select that zeroes the ID/EX control word while Decode is stalled. It also counts stall cycles and flags a stall that lasts too long.

---
 rtl/fetch_stall_control.sv | 108 ++++++++++
 tb/tb_fetch_stall_control.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_control.sv
// Program counter and IF/ID pipeline register with hazard stall, branch redirect,
// stall-cycle accounting and a sticky timeout for over-long stalls.
module fetch_stall_control #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned STALL_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] FetchedInstruction,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        BubbleSel,
    output logic [31:0] StallCycles,
    output logic        StallTimeout
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetchState_t;

    localparam logic [3:0] LIMIT = 4'(STALL_LIMIT);

    fetchState_t r_state;
    fetchState_t w_stateNext;

    logic [31:0] r_pc;
    logic [31:0] r_ifIdInstruction;
    logic [31:0] r_ifIdPcPlus4;
    logic        r_ifIdValid;
    logic [31:0] r_stallCycles;
    logic        r_stallTimeout;
    logic [3:0]  r_runCount;

    logic        w_stall;
    logic [31:0] w_pcPlus4;
    logic [3:0]  w_runCountInc;

    // A bubble in Decode cannot stall, and a redirect flushes whatever would stall.
    assign w_stall       = ~PCWrite & r_ifIdValid & ~BranchTaken;
    assign w_pcPlus4     = r_pc + 32'd4;
    assign w_runCountInc = (r_runCount == 4'd15) ? 4'd15 : r_runCount + 4'd1;

    always_comb begin
        w_stateNext = r_state;
        if (BranchTaken) begin
            w_stateNext = FLUSH;
        end else if (w_stall) begin
            w_stateNext = STALL;
        end else begin
            w_stateNext = RUN;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc              <= RESET_PC;
            r_ifIdInstruction <= 32'd0;
            r_ifIdPcPlus4     <= 32'd0;
            r_ifIdValid       <= 1'b0;
            r_stallCycles     <= 32'd0;
            r_stallTimeout    <= 1'b0;
            r_runCount        <= 4'd0;
        end else if (BranchTaken) begin
            r_pc              <= BranchTarget;
            r_ifIdInstruction <= 32'd0;
            r_ifIdPcPlus4     <= 32'd0;
            r_ifIdValid       <= 1'b0;
            r_runCount        <= 4'd0;
        end else if (w_stall) begin
            r_stallCycles <= r_stallCycles + 32'd1;
            r_runCount    <= w_runCountInc;
            // Timeout is only reported; the pipeline stays frozen until PCWrite returns.
            if (w_runCountInc == LIMIT) begin
                r_stallTimeout <= 1'b1;
            end
        end else begin
            r_pc              <= w_pcPlus4;
            r_ifIdInstruction <= FetchedInstruction;
            r_ifIdPcPlus4     <= w_pcPlus4;
            r_ifIdValid       <= 1'b1;
            r_runCount        <= 4'd0;
        end
    end

    assign PC                = r_pc;
    assign IF_ID_Instruction = r_ifIdInstruction;
    assign IF_ID_PCPlus4     = r_ifIdPcPlus4;
    assign IF_ID_Valid       = r_ifIdValid;
    assign BubbleSel         = w_stall;
    assign StallCycles       = r_stallCycles;
    assign StallTimeout      = r_stallTimeout;

endmodule

// File: tb/tb_fetch_stall_control.sv
// Directed bench for fetch_stall_control: free-run, stall, redirect, timeout,
// PC wrap and reset-mid-stall, with hand-computed expectations.
module tb_fetch_stall_control;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PCWrite;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] FetchedInstruction;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        BubbleSel;
    logic [31:0] StallCycles;
    logic        StallTimeout;

    int passCount  = 0;
    int checkCount = 0;

    fetch_stall_control #(
        .RESET_PC   (32'h0000_0000),
        .STALL_LIMIT(4)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .PCWrite           (PCWrite),
        .BranchTaken       (BranchTaken),
        .BranchTarget      (BranchTarget),
        .FetchedInstruction(FetchedInstruction),
        .PC                (PC),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .BubbleSel         (BubbleSel),
        .StallCycles       (StallCycles),
        .StallTimeout      (StallTimeout)
    );

    always #5 Clk = ~Clk;

    // Instruction memory: each address returns a distinct pattern.
    function automatic logic [31:0] instrAt(input logic [31:0] addr);
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    assign FetchedInstruction = instrAt(PC);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic pcw, input logic br,
                                 input logic [31:0] tgt);
        Reset        = rst;
        PCWrite      = pcw;
        BranchTaken  = br;
        BranchTarget = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tick();

        checkOutput("rst_pc", PC, 32'h0);
        checkOutput("rst_valid", 32'(IF_ID_Valid), 32'd0);
        checkOutput("rst_instr", IF_ID_Instruction, 32'd0);
        checkOutput("rst_pcp4", IF_ID_PCPlus4, 32'd0);
        checkOutput("rst_stalls", StallCycles, 32'd0);
        checkOutput("rst_timeout", 32'(StallTimeout), 32'd0);

        // Free-run; PCWrite low on the first cycle is ignored because Decode holds a bubble.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bubble_nostall_sel", 32'(BubbleSel), 32'd0);
        tick();
        checkOutput("run1_pc", PC, 32'd4);
        checkOutput("run1_valid", 32'(IF_ID_Valid), 32'd1);
        checkOutput("run1_instr", IF_ID_Instruction, instrAt(32'd0));
        checkOutput("run1_pcp4", IF_ID_PCPlus4, 32'd4);
        checkOutput("run1_stalls", StallCycles, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("run2_pc", PC, 32'd8);
        checkOutput("run2_pcp4", IF_ID_PCPlus4, 32'd8);

        // Two-cycle stall at PC = 8.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("stall_sel0", 32'(BubbleSel), 32'd1);
        tick();
        checkOutput("stall1_pc", PC, 32'd8);
        checkOutput("stall1_pcp4", IF_ID_PCPlus4, 32'd8);
        checkOutput("stall1_instr", IF_ID_Instruction, instrAt(32'd4));
        checkOutput("stall_sel1", 32'(BubbleSel), 32'd1);
        tick();
        checkOutput("stall2_pc", PC, 32'd8);
        checkOutput("stall2_count", StallCycles, 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("release_sel", 32'(BubbleSel), 32'd0);
        tick();
        checkOutput("release_pc", PC, 32'd12);
        checkOutput("release_instr", IF_ID_Instruction, instrAt(32'd8));

        // Redirect wins over a simultaneous stall request.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        checkOutput("br_sel", 32'(BubbleSel), 32'd0);
        tick();
        checkOutput("br_pc", PC, 32'h40);
        checkOutput("br_valid", 32'(IF_ID_Valid), 32'd0);
        checkOutput("br_instr", IF_ID_Instruction, 32'd0);
        checkOutput("br_stalls", StallCycles, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("flush_sel", 32'(BubbleSel), 32'd0);
        tick();
        checkOutput("flush_pc", PC, 32'h44);
        checkOutput("flush_valid", 32'(IF_ID_Valid), 32'd1);
        checkOutput("flush_instr", IF_ID_Instruction, instrAt(32'h40));
        checkOutput("flush_pcp4", IF_ID_PCPlus4, 32'h44);

        // Six-cycle stall; timeout must rise on the fourth stall edge.
        for (int i = 1; i <= 6; i++) begin
            tick();
            checkOutput($sformatf("to_flag%0d", i), 32'(StallTimeout),
                        (i >= 4) ? 32'd1 : 32'd0);
        end
        checkOutput("to_pc", PC, 32'h44);
        checkOutput("to_count", StallCycles, 32'd8);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("to_release_pc", PC, 32'h48);
        checkOutput("to_sticky", 32'(StallTimeout), 32'd1);

        // PC wraps from the top of the address space.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_br_pc", PC, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("wrap_pc", PC, 32'h0);
        checkOutput("wrap_pcp4", IF_ID_PCPlus4, 32'h0);
        checkOutput("wrap_instr", IF_ID_Instruction, instrAt(32'hFFFF_FFFC));

        // Reset on the third cycle of a stall clears everything.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("pre_rst_count", StallCycles, 32'd10);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("mid_rst_pc", PC, 32'h0);
        checkOutput("mid_rst_valid", 32'(IF_ID_Valid), 32'd0);
        checkOutput("mid_rst_instr", IF_ID_Instruction, 32'd0);
        checkOutput("mid_rst_count", StallCycles, 32'd0);
        checkOutput("mid_rst_timeout", 32'(StallTimeout), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mid_rst_sel", 32'(BubbleSel), 32'd0);

        // Run counter must restart from zero: three stall edges stay below the limit.
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
        end
        checkOutput("post_rst_count", StallCycles, 32'd3);
        checkOutput("post_rst_timeout", 32'(StallTimeout), 32'd0);
        tick();
        checkOutput("post_rst_timeout4", 32'(StallTimeout), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
